// File: rtl/redun_mont_pkg.sv
// Shared sizing and vector types for the redundant-form Montgomery datapath.
package redun_mont_pkg;

  localparam int WRD_BITS   = 16;
  localparam int NUM_WRDS   = 4;
  localparam int CARRY_BITS = 2;

  // Redundant vector: each word carries one overlap bit above its payload.
  typedef logic [NUM_WRDS-1:0][WRD_BITS:0]   redun0_t;
  typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] bin_t;

endpackage

// File: rtl/redun_carry_slice.sv
// Combinational ripple of WRDS_PER_CYC word adders: folds the incoming carry
// into each redundant word and passes the overflow to the next word.
module redun_carry_slice
  import redun_mont_pkg::*;
#(
  parameter int WRD_BITS     = redun_mont_pkg::WRD_BITS,
  parameter int WRDS_PER_CYC = 1
) (
  input  logic [WRDS_PER_CYC-1:0][WRD_BITS:0]   i_wrds,
  input  logic [CARRY_BITS-1:0]                 i_carry,
  output logic [WRDS_PER_CYC-1:0][WRD_BITS-1:0] o_wrds,
  output logic [CARRY_BITS-1:0]                 o_carry
);

  logic [WRD_BITS+1:0]   sum;
  logic [CARRY_BITS-1:0] c;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    sum    = '0;
    c      = i_carry;
    o_wrds = '0;
    for (int w = 0; w < WRDS_PER_CYC; w++) begin
      sum       = {1'b0, i_wrds[w]} + {{WRD_BITS{1'b0}}, c};
      o_wrds[w] = sum[WRD_BITS-1:0];
      c         = sum[WRD_BITS+1:WRD_BITS];
    end
    o_carry = c;
  end

endmodule

// File: rtl/redun_carry_resolve.sv
// Sequentially resolves inter-word carries of one redundant vector into
// canonical binary, WRDS_PER_CYC words per clock, with a held valid/ready output.
module redun_carry_resolve
  import redun_mont_pkg::*;
#(
  parameter int WRD_BITS     = redun_mont_pkg::WRD_BITS,
  parameter int NUM_WRDS     = redun_mont_pkg::NUM_WRDS,
  parameter int WRDS_PER_CYC = 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NUM_WRDS-1:0][WRD_BITS:0]    i_dat,
  input  logic                               i_val,
  output logic                               o_rdy,
  output logic [NUM_WRDS-1:0][WRD_BITS-1:0]  o_dat,
  output logic [CARRY_BITS-1:0]              o_carry,
  output logic                               o_val,
  input  logic                               i_rdy,
  output logic                               o_ovr
);

  localparam int NUM_GRPS = NUM_WRDS / WRDS_PER_CYC;
  localparam int IDX_BITS = (NUM_GRPS > 1) ? $clog2(NUM_GRPS) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_GRPS - 1);

  generate
    if ((NUM_WRDS % WRDS_PER_CYC) != 0) begin : g_bad_cfg
      $error("redun_carry_resolve: WRDS_PER_CYC must divide NUM_WRDS");
    end
  endgenerate

  logic [1:0]                               state;
  logic [IDX_BITS-1:0]                      idx;
  logic [CARRY_BITS-1:0]                    carry;
  logic [NUM_WRDS-1:0][WRD_BITS:0]          dat_q;
  logic [WRDS_PER_CYC-1:0][WRD_BITS:0]      grp_in;
  logic [WRDS_PER_CYC-1:0][WRD_BITS-1:0]    grp_out;
  logic [CARRY_BITS-1:0]                    grp_carry;

  assign o_rdy = (state == ST_IDLE);

  // Select the word group addressed by idx.
  always_comb begin
    grp_in = '0;
    for (int g = 0; g < NUM_GRPS; g++) begin
      if (idx == IDX_BITS'(g)) grp_in = dat_q[g*WRDS_PER_CYC +: WRDS_PER_CYC];
    end
  end

  redun_carry_slice #(
    .WRD_BITS     (WRD_BITS),
    .WRDS_PER_CYC (WRDS_PER_CYC)
  ) u_slice (
    .i_wrds  (grp_in),
    .i_carry (carry),
    .o_wrds  (grp_out),
    .o_carry (grp_carry)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry   <= '0;
      // NOTE: the capture register is reset too, so a reset leaves no stale vector behind.
      dat_q   <= '0;
      o_dat   <= '0;
      o_carry <= '0;
      o_val   <= 1'b0;
      o_ovr   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_val) begin
            dat_q <= i_dat;
            carry <= '0;
            idx   <= '0;
            state <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          for (int g = 0; g < NUM_GRPS; g++) begin
            if (idx == IDX_BITS'(g)) o_dat[g*WRDS_PER_CYC +: WRDS_PER_CYC] <= grp_out;
          end
          carry <= grp_carry;
          if (idx == LAST_IDX) begin
            o_carry <= grp_carry;
            o_val   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (i_rdy) begin
            o_val <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // An input arriving while busy is lost; remember that until reset.
      if (i_val && (state != ST_IDLE)) o_ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_redun_carry_resolve.sv
// Bench for redun_carry_resolve: two instances (1 and 2 words per cycle) driven
// in lockstep, checked against an arithmetic model of the redundant value.
module tb_redun_carry_resolve;
  import redun_mont_pkg::*;

  typedef struct {
    redun0_t    dat;
    bin_t       exp_dat;
    logic [1:0] exp_carry;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_val = 1'b0;
  logic       i_rdy = 1'b1;
  redun0_t    i_dat = '0;

  logic       o_rdy   [2];
  logic       o_val   [2];
  logic       o_ovr   [2];
  bin_t       o_dat   [2];
  logic [1:0] o_carry [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  redun_carry_resolve #(.WRD_BITS(16), .NUM_WRDS(4), .WRDS_PER_CYC(1)) u_dut_w1 (
    .i_clk (clk), .i_rst_n (rst_n), .i_dat (i_dat), .i_val (i_val),
    .o_rdy (o_rdy[0]), .o_dat (o_dat[0]), .o_carry (o_carry[0]),
    .o_val (o_val[0]), .i_rdy (i_rdy), .o_ovr (o_ovr[0])
  );

  redun_carry_resolve #(.WRD_BITS(16), .NUM_WRDS(4), .WRDS_PER_CYC(2)) u_dut_w2 (
    .i_clk (clk), .i_rst_n (rst_n), .i_dat (i_dat), .i_val (i_val),
    .o_rdy (o_rdy[1]), .o_dat (o_dat[1]), .o_carry (o_carry[1]),
    .o_val (o_val[1]), .i_rdy (i_rdy), .o_ovr (o_ovr[1])
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the redundant vector is just sum(word[i] * 2^(16*i)).
  function automatic void model(input redun0_t d, output bin_t q, output logic [1:0] c);
    logic [79:0] total;
    total = '0;
    for (int i = 0; i < 4; i++) total = total + (80'(d[i]) << (16 * i));
    q = total[63:0];
    c = total[65:64];
  endfunction

  function automatic redun0_t mk(input logic [16:0] w3, input logic [16:0] w2,
                                 input logic [16:0] w1, input logic [16:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  // Called just after a negedge; returns at the negedge after the accept edge.
  task automatic accept(input redun0_t d);
    i_dat = d;
    i_val = 1'b1;
    @(negedge clk);
    i_val = 1'b0;
  endtask

  task automatic run_vec(input redun0_t d, input bin_t ed, input logic [1:0] ec, input string tag);
    int first [2];
    int highs [2];
    first = '{-1, -1};
    highs = '{0, 0};
    i_rdy = 1'b1;
    accept(d);
    for (int k = 0; k < 2; k++) check($sformatf("%s d%0d rdy_busy", tag, k), 80'(o_rdy[k]), 80'(0));
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (o_val[k]) begin
          highs[k]++;
          if (first[k] < 0) begin
            first[k] = n;
            check($sformatf("%s d%0d dat", tag, k), 80'(o_dat[k]), 80'(ed));
            check($sformatf("%s d%0d carry", tag, k), 80'(o_carry[k]), 80'(ec));
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s d%0d latency", tag, k), 80'(first[k]), 80'(lat(k)));
      check($sformatf("%s d%0d val_cycles", tag, k), 80'(highs[k]), 80'(1));
      check($sformatf("%s d%0d rdy_after", tag, k), 80'(o_rdy[k]), 80'(1));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s d%0d rdy", tag, k), 80'(o_rdy[k]), 80'(1));
      check($sformatf("%s d%0d val", tag, k), 80'(o_val[k]), 80'(0));
      check($sformatf("%s d%0d dat", tag, k), 80'(o_dat[k]), 80'(0));
      check($sformatf("%s d%0d carry", tag, k), 80'(o_carry[k]), 80'(0));
      check($sformatf("%s d%0d ovr", tag, k), 80'(o_ovr[k]), 80'(0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs [5];
    redun0_t    d;
    redun0_t    va;
    bin_t       ed;
    logic [1:0] ec;
    int         t;
    int         extra;

    vecs[0] = '{mk(17'h00000, 17'h00000, 17'h00000, 17'h00000), 64'h0000_0000_0000_0000, 2'd0};
    vecs[1] = '{mk(17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h10000), 64'h0000_0000_0000_0000, 2'd1};
    vecs[2] = '{mk(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF), 64'h0001_0001_0000_FFFF, 2'd2};
    vecs[3] = '{mk(17'h00004, 17'h00003, 17'h00002, 17'h00001), 64'h0004_0003_0002_0001, 2'd0};
    vecs[4] = '{mk(17'h00000, 17'h00000, 17'h00000, 17'h1FFFF), 64'h0000_0000_0001_FFFF, 2'd0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 5; i++) run_vec(vecs[i].dat, vecs[i].exp_dat, vecs[i].exp_carry, $sformatf("tbl%0d", i));

    // Randomized against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      for (int w = 0; w < 4; w++) d[w] = 17'($urandom);
      model(d, ed, ec);
      run_vec(d, ed, ec, $sformatf("rnd%0d", i));
    end

    // Backpressure: hold the result for 10 cycles
    d = vecs[2].dat;
    model(d, ed, ec);
    i_rdy = 1'b0;
    accept(d);
    t = 0;
    while (!o_val[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("bp wait_val", 80'(o_val[0]), 80'(1));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("bp%0d d%0d val", n, k), 80'(o_val[k]), 80'(1));
        check($sformatf("bp%0d d%0d dat", n, k), 80'(o_dat[k]), 80'(ed));
        check($sformatf("bp%0d d%0d carry", n, k), 80'(o_carry[k]), 80'(ec));
      end
    end
    i_rdy = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("bp release d%0d val", k), 80'(o_val[k]), 80'(0));
      check($sformatf("bp release d%0d rdy", k), 80'(o_rdy[k]), 80'(1));
      check($sformatf("bp release d%0d ovr", k), 80'(o_ovr[k]), 80'(0));
    end

    // Drop: second input in RESOLVE, third in DONE, fourth on the handshake cycle
    va = vecs[3].dat;
    model(va, ed, ec);
    i_rdy = 1'b0;
    accept(va);
    accept(vecs[2].dat);
    for (int k = 0; k < 2; k++) check($sformatf("drop1 d%0d ovr", k), 80'(o_ovr[k]), 80'(1));
    t = 0;
    while (!o_val[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("drop wait_val", 80'(o_val[0]), 80'(1));
    accept(vecs[1].dat);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("drop2 d%0d val", k), 80'(o_val[k]), 80'(1));
      check($sformatf("drop2 d%0d dat", k), 80'(o_dat[k]), 80'(ed));
      check($sformatf("drop2 d%0d carry", k), 80'(o_carry[k]), 80'(ec));
    end
    i_rdy = 1'b1;
    accept(vecs[2].dat);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("drop hs d%0d val", k), 80'(o_val[k]), 80'(0));
      check($sformatf("drop hs d%0d rdy", k), 80'(o_rdy[k]), 80'(1));
    end
    extra = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (o_val[k] || !o_rdy[k]) extra++;
    end
    check("drop no_extra_val", 80'(extra), 80'(0));
    for (int k = 0; k < 2; k++) check($sformatf("drop sticky d%0d ovr", k), 80'(o_ovr[k]), 80'(1));

    // Reset mid-RESOLVE (the 1-word-per-cycle instance sits at idx 2)
    accept(vecs[2].dat);
    @(negedge clk);
    @(negedge clk);
    check("mid d0 busy", 80'(o_rdy[0]), 80'(0));
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 4; w++) d[w] = 17'($urandom);
    model(d, ed, ec);
    run_vec(d, ed, ec, "post_rst");
    run_vec(vecs[2].dat, vecs[2].exp_dat, vecs[2].exp_carry, "post_rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
